// File: rtl/ul_pkg.sv
// rtl/ul_pkg.sv - shared op codes and default widths for the ul_pipe logic unit
package ul_pkg;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam int UL_WIDTH = 8;
    localparam int UL_CNT_W = 8;

endpackage

// File: rtl/ul_pipe_if.sv
// rtl/ul_pipe_if.sv - operand/result handshake bundle for ul_pipe; parity wire present under UL_PIPE_PARITY_EN
interface ul_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       S;
    logic             acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Out;
    logic             zero;
    logic [CNT_W-1:0] count;
`ifdef UL_PIPE_PARITY_EN
    logic             parity;
`endif

    modport slave (
        input  in_valid, A, B, S, acc, acc_clr, out_ready,
        output in_ready, out_valid, Out, zero, count
`ifdef UL_PIPE_PARITY_EN
        , output parity
`endif
    );

    modport master (
        output in_valid, A, B, S, acc, acc_clr, out_ready,
        input  in_ready, out_valid, Out, zero, count
`ifdef UL_PIPE_PARITY_EN
        , input parity
`endif
    );

endinterface

// File: rtl/ul_cln.sv
// rtl/ul_cln.sv - combinational WIDTH-bit logic cell array computing f(a, b, s)
module ul_cln
    import ul_pkg::*;
#(
    parameter int WIDTH = UL_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] f
);

    always_comb begin
        f = '0;
        case (s)
            OP_NOT:  f = ~a;
            OP_XOR:  f = a ^ b;
            OP_OR:   f = a | b;
            OP_AND:  f = a & b;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/ul_pipe.sv
// rtl/ul_pipe.sv - registered logic unit with valid/ready, accumulator, zero flag and op counter; optional parity via UL_PIPE_PARITY_EN
module ul_pipe
    import ul_pkg::*;
#(
    parameter int WIDTH = UL_WIDTH,
    parameter int CNT_W = UL_CNT_W
) (
    input  logic    clk,
    input  logic    reset,
    ul_pipe_if.slave bus
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef UL_PIPE_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] f;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // A clear arriving with an accumulate op zeroes the operand for that op.
    always_comb begin
        b_sel = bus.B;
        if (bus.acc) begin
            b_sel = bus.acc_clr ? '0 : acc_q;
        end
    end

    ul_cln #(.WIDTH(WIDTH)) u_cln (
        .a (bus.A),
        .b (b_sel),
        .s (bus.S),
        .f (f)
    );

    always_comb begin
        out_d       = out_q;
        acc_d       = acc_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
`ifdef UL_PIPE_PARITY_EN
        parity_d    = parity_q;
`endif
        if (accept) begin
            out_d       = f;
            acc_d       = f;
            zero_d      = (f == '0);
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + CNT_W'(1);
`ifdef UL_PIPE_PARITY_EN
            parity_d    = ^f;
`endif
        end else begin
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            if (bus.acc_clr) begin
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            acc_q       <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
`ifdef UL_PIPE_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            out_q       <= out_d;
            acc_q       <= acc_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
`ifdef UL_PIPE_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.Out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.count     = cnt_q;
`ifdef UL_PIPE_PARITY_EN
    assign bus.parity    = parity_q;
`endif

endmodule

// File: tb/tb_ul_pipe.sv
// tb/tb_ul_pipe.sv - directed self-checking bench for ul_pipe (parity checks under UL_PIPE_PARITY_EN)
module tb_ul_pipe;
    import ul_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ul_pipe_if #(.WIDTH(UL_WIDTH), .CNT_W(UL_CNT_W)) bus  ();
    ul_pipe_if #(.WIDTH(UL_WIDTH), .CNT_W(4))        bus4 ();

    ul_pipe #(.WIDTH(UL_WIDTH), .CNT_W(UL_CNT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    ul_pipe #(.WIDTH(UL_WIDTH), .CNT_W(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                      input logic use_acc, input logic clr);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.S        = s;
        bus.acc      = use_acc;
        bus.acc_clr  = clr;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.acc      = 1'b0;
        bus.acc_clr  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.A = '0; bus.B = '0; bus.S = '0; bus.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.A = '0; bus4.B = '0; bus4.S = '0;
        bus4.acc = 1'b0; bus4.acc_clr = 1'b0; bus4.out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;

        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_out",   bus.Out, 8'h00);
        check_eq("rst_zero",  bus.zero, 1);
        check_eq("rst_count", bus.count, 0);
        check_eq("rst_ready", bus.in_ready, 1);

        // four ops back to back
        op(8'hF0, 8'h3C, OP_AND, 0, 0); step();
        check_eq("and_out", bus.Out, 8'h30); check_eq("and_valid", bus.out_valid, 1);
        op(8'hF0, 8'h3C, OP_OR, 0, 0);  step();
        check_eq("or_out", bus.Out, 8'hFC);  check_eq("or_valid", bus.out_valid, 1);
        op(8'hF0, 8'h3C, OP_XOR, 0, 0); step();
        check_eq("xor_out", bus.Out, 8'hCC); check_eq("xor_valid", bus.out_valid, 1);
        op(8'hF0, 8'h3C, OP_NOT, 0, 0); step();
        check_eq("not_out", bus.Out, 8'h0F); check_eq("not_valid", bus.out_valid, 1);
        check_eq("count4", bus.count, 4);
        idle(); step();
        check_eq("drain_valid", bus.out_valid, 0);
        check_eq("drain_hold", bus.Out, 8'h0F);

        // accumulate chain
        op(8'hF0, 8'h3C, OP_AND, 0, 0); step();
        check_eq("acc0_out", bus.Out, 8'h30);
        op(8'h0F, 8'h00, OP_XOR, 1, 0); step();
        check_eq("acc1_out", bus.Out, 8'h3F);
        op(8'hAA, 8'h00, OP_OR, 1, 1);  step();
        check_eq("accclr_out", bus.Out, 8'hAA);
        op(8'h00, 8'h00, OP_OR, 1, 0);  step();
        check_eq("acc_reg_AA", bus.Out, 8'hAA);

        // clear with no accept
        idle(); bus.acc_clr = 1'b1; step();
        op(8'h00, 8'h55, OP_OR, 1, 0); step();
        check_eq("clr_idle", bus.Out, 8'h00);

        // zero flag
        op(8'hAA, 8'h55, OP_AND, 0, 0); step();
        check_eq("zero_out", bus.Out, 8'h00); check_eq("zero_set", bus.zero, 1);
        op(8'h01, 8'h00, OP_OR, 0, 0);  step();
        check_eq("nz_out", bus.Out, 8'h01);   check_eq("zero_clr", bus.zero, 0);

        // backpressure from a fresh reset
        idle(); reset = 1'b1; step(); reset = 1'b0;
        op(8'hF0, 8'h3C, OP_AND, 0, 0); step();
        check_eq("bp_first", bus.Out, 8'h30);
        op(8'hFF, 8'h00, OP_OR, 0, 0);
        bus.out_ready = 1'b0;
        #1;
        check_eq("bp_ready0", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_hold_out", bus.Out, 8'h30);
            check_eq("bp_hold_cnt", bus.count, 1);
            check_eq("bp_hold_vld", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp_ready1", bus.in_ready, 1);
        step();
        check_eq("bp_second", bus.Out, 8'hFF);
        check_eq("bp_cnt2", bus.count, 2);

        // build Out=3F, acc=3F, count=5, then reset mid-stream
        op(8'h00, 8'h00, OP_OR, 0, 0);  step();
        op(8'hF0, 8'h3C, OP_AND, 0, 0); step();
        op(8'h0F, 8'h00, OP_XOR, 1, 0); step();
        check_eq("pre_rst_out", bus.Out, 8'h3F);
        check_eq("pre_rst_cnt", bus.count, 5);
        idle(); reset = 1'b1; step(); reset = 1'b0;
        check_eq("mid_rst_vld",  bus.out_valid, 0);
        check_eq("mid_rst_out",  bus.Out, 8'h00);
        check_eq("mid_rst_zero", bus.zero, 1);
        check_eq("mid_rst_cnt",  bus.count, 0);
        op(8'h0F, 8'h00, OP_XOR, 1, 0); step();
        check_eq("post_rst_acc", bus.Out, 8'h0F);

`ifdef UL_PIPE_PARITY_EN
        op(8'h07, 8'h00, OP_OR, 0, 0); step();
        check_eq("par_out", bus.Out, 8'h07);
        check_eq("par_odd", bus.parity, 1);
        op(8'h03, 8'h00, OP_OR, 0, 0); step();
        check_eq("par_even", bus.parity, 0);
`endif
        idle();

        // counter wrap on a 4-bit counter instance
        bus4.in_valid = 1'b1; bus4.A = 8'h01; bus4.S = OP_OR;
        for (int i = 0; i < 15; i++) step();
        check_eq("cnt4_15", bus4.count, 15);
        step();
        check_eq("cnt4_wrap", bus4.count, 0);
        bus4.in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ul_pipe.md
Name: ul_pipe

Overview:
- Parametrised WIDTH-bit logic unit with the team's standard 2-bit op encoding (NOT A / XOR / OR / AND).
- Adds a registered output stage with valid/ready handshake, an accumulator that can replace operand B, a zero flag and an accepted-operation counter.
- Successor to the fixed 4-bit combinational logic unit; sits between operand sources and the datapath result bus.

Parameters:
- WIDTH, 8: operand/result width in bits (>=1).
- CNT_W, 8: width of the accepted-operation counter (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set A/B/S/acc presented.
- in_ready  output  1  block can accept an operation this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- S  input  2  op select: 00 ~A, 01 A^B', 10 A|B', 11 A&B'.
- acc  input  1  1: B' = accumulator register; 0: B' = B.
- acc_clr  input  1  synchronous clear of the accumulator.
- out_valid  output  1  Out/zero hold a result not yet taken.
- out_ready  input  1  consumer takes the result this cycle.
- Out  output  WIDTH  registered result.
- zero  output  1  registered, 1 when Out == 0.
- count  output  CNT_W  number of accepted operations, modulo 2^CNT_W.

Behaviour:
- Reset (reset=1 at edge): out_valid=0, Out=0, zero=1, count=0, accumulator=0. Reset overrides all other inputs in the same cycle.
- After reset, in_ready=1.
- in_ready = !out_valid || out_ready. This is combinational; there is no path from in_valid to in_ready.
- Accept = in_valid && in_ready. On accept:
  - Out <= f(A, B', S); zero <= (f == 0).
  - accumulator <= f.
  - out_valid <= 1.
  - count <= count+1, wrapping from 2^CNT_W-1 to 0.
- Latency: 1 cycle. Result is visible the cycle after acceptance.
- Throughput: 1 operation/cycle while out_ready=1.
- No accept and out_ready=1: out_valid <= 0. Out and zero keep their last values.
- Stall: out_valid=1 and out_ready=0 means no accept. Out, zero, accumulator and count are stable.
- Width rule: purely bitwise operations, no carries, no extension.
- acc_clr without accept: accumulator <= 0.
- acc_clr together with an accept:
  - If acc=1, B' = 0 for that operation.
  - The accumulator then takes the new result; the accept wins over the clear.
- Back-to-back accumulate ops use the previous accepted result, even if it has not yet been consumed downstream.
- Unaccepted cycles never change the accumulator, except via acc_clr.
- No internal FSM beyond the out_valid bit: EMPTY (out_valid=0) / FULL (out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready with no accept.
  - FULL -> FULL on out_ready with accept, or on a stall.

Optional Feature:
- Macro UL_PIPE_PARITY_EN.
- Defined: extra output `parity` (1 bit), registered with Out, = XOR of all bits of f. Reset value 0. Holds during stall exactly like Out.
- Undefined: no parity port, no parity register; all other behaviour identical.

Decomposition:
- Shared package ul_pkg holds:
  - op-code localparams OP_NOT=2'b00, OP_XOR=2'b01, OP_OR=2'b10, OP_AND=2'b11;
  - the default WIDTH and CNT_W constants.
- One natural sub-module: ul_cln, a combinational WIDTH-parametrised logic cell array computing f(A, B', S). ul_pipe instantiates it once and adds the operand mux, registers, handshake and counter.

Test Plan:
- WIDTH=8, out_ready=1. Accept A=F0, B=3C with S=11, 10, 01, 00 on consecutive cycles → Out = 30, FC, CC, 0F one cycle each after input; out_valid=1 throughout; count=4.
- Accumulate chain:
  - A=F0, B=3C, S=11 → Out=30.
  - Then A=0F, acc=1, S=01 → Out=3F.
  - Then acc_clr=1 with A=AA, acc=1, S=10 → Out=AA; accumulator=AA.
- Zero flag: A=AA, B=55, S=11 → Out=00, zero=1. Next op A=01, B=00, S=10 → Out=01, zero=0.
- Backpressure:
  - Accept A=F0, B=3C, S=11 (Out=30), then hold out_ready=0 for 3 cycles with in_valid=1, A=FF → in_ready=0, Out stays 30, count stays 1.
  - Raise out_ready → second op accepted that cycle, Out=FF next cycle.
- Reset mid-stream: with out_valid=1, Out=3F, accumulator=3F, count=5, assert reset for 1 cycle → out_valid=0, Out=00, zero=1, count=0. Following acc=1, A=0F, S=01 → Out=0F.
- CNT_W=4: 16 accepts → count=0. With UL_PIPE_PARITY_EN defined: A=07, B=00, S=10 → Out=07, parity=1.
